// File: rtl/rom_read_cache.sv
// Direct-mapped 64-bit word read cache between the core ROM fetch port and the ddram read port.
// Latency: hit = ack toggle 2 cycles after the request is seen; miss = ack toggle 1 cycle after mem_ack.
// Backpressure: one request outstanding per side; a new rom_req toggle stays pending until the FSM is idle.
// Optional hit/miss counters are built when ROM_READ_CACHE_STATS_EN is defined.
module rom_read_cache #(
    parameter int LINES_LOG2 = 8,
    parameter int ADDR_W     = 20
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_req,
    output logic              rom_ack,
    output logic [63:0]       rom_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [63:0]       mem_data
`ifdef ROM_READ_CACHE_STATS_EN
  , output logic [31:0]       hit_count
  , output logic [31:0]       miss_count
`endif
);

    localparam int TAG_W = ADDR_W - LINES_LOG2;
    localparam int LINES = 1 << LINES_LOG2;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [63:0]      dat;
    } line_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FILL   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    line_t             ram [LINES];
    line_t             ram_q;
    line_t             line_wr;
    logic [LINES-1:0]  valid;

    logic [ADDR_W-1:0]     req_addr;
    logic [LINES_LOG2-1:0] req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [LINES_LOG2-1:0] rom_idx;
    logic                  flush_seen;

    logic rom_pend;
    logic mem_pend;
    logic hit;

    // control strobes from the output process
    logic accept;
    logic lookup_hit;
    logic lookup_miss;
    logic fill_done;
    logic install;

    assign rom_pend = (rom_req != rom_ack);
    assign mem_pend = (mem_req != mem_ack);
    assign req_idx  = req_addr[LINES_LOG2-1:0];
    assign req_tag  = req_addr[ADDR_W-1:LINES_LOG2];
    assign rom_idx  = rom_addr[LINES_LOG2-1:0];
    // a flush in the lookup cycle makes the line look invalid
    assign hit      = valid[req_idx] && !flush && (ram_q.tag == req_tag);

    // state register
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!flush && rom_pend) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = hit ? IDLE : FILL;
            FILL:    if (!mem_pend) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // per-state control strobes
    always_comb begin
        accept      = 1'b0;
        lookup_hit  = 1'b0;
        lookup_miss = 1'b0;
        fill_done   = 1'b0;
        install     = 1'b0;
        line_wr.tag = req_tag;
        line_wr.dat = mem_data;
        case (state)
            IDLE:    accept = !flush && rom_pend;
            LOOKUP: begin
                lookup_hit  = hit;
                lookup_miss = !hit;
            end
            FILL: begin
                fill_done = !mem_pend;
                // data from a fill that overlapped a flush may be stale; return it but do not keep it
                install   = !mem_pend && !flush_seen && !flush;
            end
            default: ;
        endcase
    end

    // handshake toggles, returned data and latched request address
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rom_ack    <= 1'b0;
            rom_data   <= 64'd0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            req_addr   <= '0;
            flush_seen <= 1'b0;
        end else begin
            if (accept) begin
                req_addr <= rom_addr;
            end
            if (lookup_hit) begin
                rom_data <= ram_q.dat;
                rom_ack  <= ~rom_ack;
            end
            if (lookup_miss) begin
                mem_addr   <= req_addr;
                mem_req    <= ~mem_req;
                flush_seen <= 1'b0;
            end
            if (state == FILL && flush) begin
                flush_seen <= 1'b1;
            end
            if (fill_done) begin
                rom_data <= mem_data;
                rom_ack  <= ~rom_ack;
            end
        end
    end

    // valid bits: flush wipes everything in one cycle, a clean fill sets its line
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (install) begin
            valid[req_idx] <= 1'b1;
        end
    end

    // tag/data block RAM: one write port for fills, registered read on request accept
    always_ff @(posedge clk_sys) begin
        if (install) begin
            ram[req_idx] <= line_wr;
        end
        if (accept) begin
            ram_q <= ram[rom_idx];
        end
    end

`ifdef ROM_READ_CACHE_STATS_EN
    logic flush_q;

    // saturating hit/miss counters, cleared on reset and on the rising edge of flush
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            flush_q    <= 1'b0;
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            flush_q <= flush;
            if (flush && !flush_q) begin
                hit_count  <= 32'd0;
                miss_count <= 32'd0;
            end else begin
                if (lookup_hit && hit_count != 32'hFFFF_FFFF) begin
                    hit_count <= hit_count + 32'd1;
                end
                if (lookup_miss && miss_count != 32'hFFFF_FFFF) begin
                    miss_count <= miss_count + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rom_read_cache.sv
// Scoreboard bench for rom_read_cache: directed requests push expected responses,
// a monitor checks every rom_ack / mem_req toggle against them.
// A toggle-handshake ddram model answers each fetch 5 cycles after mem_req toggles.
module tb_rom_read_cache;

    localparam logic [63:0] D10  = 64'h0123456789ABCDEF;
    localparam logic [63:0] D110 = 64'hFEDCBA9876543210;
    localparam logic [63:0] D20  = 64'hCAFEF00DDEADBEEF;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        flush;
    logic [19:0] rom_addr;
    logic        rom_req;
    logic        rom_ack;
    logic [63:0] rom_data;
    logic [19:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [63:0] mem_data;
`ifdef ROM_READ_CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    typedef struct {
        logic [63:0] d;
        bit          hit;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [19:0] mem_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int mem_ack_cyc = 0;

    rom_read_cache #(.LINES_LOG2(8), .ADDR_W(20)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .flush      (flush),
        .rom_addr   (rom_addr),
        .rom_req    (rom_req),
        .rom_ack    (rom_ack),
        .rom_data   (rom_data),
        .mem_addr   (mem_addr),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data)
`ifdef ROM_READ_CACHE_STATS_EN
      , .hit_count  (hit_count)
      , .miss_count (miss_count)
`endif
    );

    initial forever #5 clk_sys = ~clk_sys;

    initial forever begin
        @(posedge clk_sys);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
    endtask

    function automatic logic [63:0] ddr_word(input logic [19:0] a);
        case (a)
            20'h00010: ddr_word = D10;
            20'h00110: ddr_word = D110;
            20'h00020: ddr_word = D20;
            default:   ddr_word = 64'h0;
        endcase
    endfunction

    // ddram model: acknowledges each mem_req toggle 5 cycles later
    initial begin
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_data = 64'h0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (reset) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (mem_req != mem_ack) begin
                cnt++;
                if (cnt == 6) begin
                    mem_data = ddr_word(mem_addr);
                    mem_ack = mem_req;
                    mem_ack_cyc = cyc;
                    cnt = 0;
                end
            end
        end
    end

    // monitor: every toggle on either side is matched against the scoreboard
    initial begin
        logic prev_ack;
        logic prev_mreq;
        logic rt;
        logic mt;
        exp_t e;
        logic [19:0] ea;
        prev_ack = 1'b0;
        prev_mreq = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            rt = (rom_ack != prev_ack);
            mt = (mem_req != prev_mreq);
            prev_ack = rom_ack;
            prev_mreq = mem_req;
            if (mt) begin
                check("no_dual_toggle", 64'(rt), 64'd0);
                if (mem_q.size() == 0) begin
                    check("unexpected_mem_req", 64'(mem_addr), 64'hFFFFFFFFFFFFFFFF);
                end else begin
                    ea = mem_q.pop_front();
                    check("mem_addr", 64'(mem_addr), 64'(ea));
                end
            end
            if (rt) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rom_ack", rom_data, 64'hFFFFFFFFFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("rom_data", rom_data, e.d);
                    if (e.hit) check("hit_latency", 64'(cyc - e.cyc), 64'd2);
                    else       check("miss_latency", 64'(cyc - mem_ack_cyc), 64'd1);
                end
            end
        end
    end

    // toggle rom_req as soon as the previous request has been acknowledged
    task automatic issue(input logic [19:0] a, input logic [63:0] d, input bit hit);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk_sys);
        while (rom_req !== rom_ack && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        if (n >= 200) timeout("issue_wait");
        rom_addr = a;
        rom_req = ~rom_req;
        e.d = d;
        e.hit = hit;
        e.cyc = cyc;
        exp_q.push_back(e);
        if (!hit) mem_q.push_back(a);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk_sys);
        while ((rom_req !== rom_ack || mem_req !== mem_ack) && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        if (n >= 200) timeout(name);
        check({name, "_rom_pending"}, 64'(exp_q.size()), 64'd0);
        check({name, "_mem_pending"}, 64'(mem_q.size()), 64'd0);
    endtask

    task automatic wait_fill();
        int n;
        n = 0;
        @(negedge clk_sys);
        while (mem_req === mem_ack && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        if (n >= 200) timeout("wait_fill");
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        rom_req = 1'b0;
        rom_addr = 20'h0;
        repeat (3) @(negedge clk_sys);
        check("rst_rom_ack", 64'(rom_ack), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_rom_data", rom_data, 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        reset = 1'b0;

        // cold miss, then hit on the same word
        issue(20'h00010, D10, 1'b0);
        wait_idle("cold_miss");
        issue(20'h00010, D10, 1'b1);
        wait_idle("hit");

        // same index, different tag evicts and re-fetches
        issue(20'h00110, D110, 1'b0);
        wait_idle("conflict_a");
        issue(20'h00010, D10, 1'b0);
        wait_idle("conflict_b");
`ifdef ROM_READ_CACHE_STATS_EN
        check("stats_hits", 64'(hit_count), 64'd1);
        check("stats_misses", 64'(miss_count), 64'd3);
`endif

        // flush during a fill: data returned but not installed
        issue(20'h00020, D20, 1'b0);
        wait_fill();
        @(negedge clk_sys);
        flush = 1'b1;
        @(negedge clk_sys);
        flush = 1'b0;
        wait_idle("flush_fill");
`ifdef ROM_READ_CACHE_STATS_EN
        check("stats_hits_flushed", 64'(hit_count), 64'd0);
        check("stats_misses_flushed", 64'(miss_count), 64'd0);
`endif
        issue(20'h00020, D20, 1'b0);
        wait_idle("flush_refetch");

        // flush held high blocks acceptance; afterwards everything misses
        @(negedge clk_sys);
        flush = 1'b1;
        issue(20'h00010, D10, 1'b0);
        repeat (4) @(negedge clk_sys);
        check("flush_blocks_ack", 64'(rom_req ^ rom_ack), 64'd1);
        check("flush_blocks_mem", 64'(mem_req ^ mem_ack), 64'd0);
        flush = 1'b0;
        wait_idle("flush_block");
        issue(20'h00020, D20, 1'b0);
        wait_idle("rewarm");

        // back-to-back hits, each new toggle in the cycle the ack appears
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) issue(20'h00010, D10, 1'b1);
            else            issue(20'h00020, D20, 1'b1);
        end
        wait_idle("back_to_back");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
